// File: rtl/im_arbiter_if.sv
// im_arbiter_if: fetch, loader and instruction-RAM signals seen by the arbiter.
interface im_arbiter_if #(parameter int AW = 10);
  logic f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_pc, f_rdata;
  logic l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic locked;
  modport slave (
    input f_req, f_pc, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
    output mem_en, mem_we, mem_addr, mem_wdata, locked
  );
  modport master (
    output f_req, f_pc, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    input f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
    input mem_en, mem_we, mem_addr, mem_wdata, locked
  );
endinterface

// File: rtl/im_arbiter.sv
// im_arbiter: shares the single-port instruction RAM between fetch and the loader.
module im_arbiter #(
  parameter int AW = 10,
  parameter int STARVE_LIMIT = 4,
  parameter int CW = 3
) (
  input logic clk,
  input logic reset,
  im_arbiter_if.slave bus
);
  typedef enum logic {NORMAL, LOCK} state_t;
  state_t state;
  logic [CW-1:0] starve_cnt;
  logic r_f, r_l, r_err, r_rd;
  logic starved, any, mis;
  logic [31:0] addr;
  logic unused_bits;
  // Loader beats fetch only once it has waited STARVE_LIMIT cycles
  assign starved = bus.l_req && starve_cnt == CW'(STARVE_LIMIT);
  assign bus.f_gnt = reset && state == NORMAL && bus.f_req && !starved;
  assign bus.l_gnt = reset && bus.l_req && !bus.f_gnt;
  assign any = bus.f_gnt || bus.l_gnt;
  assign addr = bus.l_gnt ? bus.l_addr : bus.f_pc;
  assign mis = |addr[1:0];
  assign unused_bits = ^{addr[31:AW+2]};
  assign bus.mem_en = any && !mis;
  assign bus.mem_we = bus.l_gnt && bus.l_we && !mis;
  assign bus.mem_addr = bus.mem_en ? addr[AW+1:2] : '0;
  assign bus.mem_wdata = bus.l_gnt ? bus.l_wdata : '0;
  assign bus.locked = state == LOCK;
  assign bus.f_rvalid = r_f;
  assign bus.f_err = r_f && r_err;
  assign bus.f_rdata = r_f && !r_err ? bus.mem_rdata : '0;
  assign bus.l_rvalid = r_l;
  assign bus.l_err = r_l && r_err;
  assign bus.l_rdata = r_l && !r_err && r_rd ? bus.mem_rdata : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= NORMAL;
      starve_cnt <= '0;
      r_f <= 1'b0;
      r_l <= 1'b0;
      r_err <= 1'b0;
      r_rd <= 1'b0;
    end else begin
      r_f <= bus.f_gnt;
      r_l <= bus.l_gnt;
      r_err <= any && mis;
      r_rd <= !(bus.l_gnt && bus.l_we);
      starve_cnt <= bus.l_req && !bus.l_gnt ?
                    (starved ? starve_cnt : starve_cnt + 1'b1) : '0;
      if (state == NORMAL)
        state <= bus.l_gnt && bus.l_lock ? LOCK : NORMAL;
      else
        state <= bus.l_lock ? LOCK : NORMAL;
    end
  end
endmodule

// File: tb/tb_im_arbiter.sv
// tb_im_arbiter: directed checks of arbitration, lock, errors and reset with a behavioural RAM.
module tb_im_arbiter;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rd_q = '0;
  im_arbiter_if #(.AW(AW)) bus ();
  im_arbiter #(.AW(AW), .STARVE_LIMIT(4), .CW(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      rd_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rd_q;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'hA000_0000 + i;
    bus.f_req = 1'b1; bus.f_pc = 32'h8;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h4; bus.l_wdata = 32'h1234; bus.l_lock = 1'b1;
    #3;
    chk("rst_f_gnt", {31'd0, bus.f_gnt}, 0);
    chk("rst_l_gnt", {31'd0, bus.l_gnt}, 0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_locked", {31'd0, bus.locked}, 0);
    bus.f_req = 0; bus.l_req = 0; bus.l_we = 0; bus.l_lock = 0; bus.l_wdata = 0;
    step(); step();
    reset = 1'b1;
    step();
    chk("idle_mem_en", {31'd0, bus.mem_en}, 0);
    // basic fetch of word 2
    bus.f_req = 1; bus.f_pc = 32'h8; settle();
    chk("f1_gnt", {31'd0, bus.f_gnt}, 1);
    chk("f1_mem_addr", {22'd0, bus.mem_addr}, 2);
    chk("f1_mem_we", {31'd0, bus.mem_we}, 0);
    step(); bus.f_req = 0; settle();
    chk("f1_rvalid", {31'd0, bus.f_rvalid}, 1);
    chk("f1_rdata", bus.f_rdata, 32'hA000_0002);
    chk("f1_err", {31'd0, bus.f_err}, 0);
    chk("f1_l_rvalid", {31'd0, bus.l_rvalid}, 0);
    // starvation: fetch wins four times, then the loader
    step(); bus.f_req = 1; bus.f_pc = 32'h20; bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h10; settle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("st_f_gnt%0d", k), {31'd0, bus.f_gnt}, 1);
      chk($sformatf("st_l_gnt%0d", k), {31'd0, bus.l_gnt}, 0);
      step();
    end
    chk("st_l_win", {31'd0, bus.l_gnt}, 1);
    chk("st_f_lose", {31'd0, bus.f_gnt}, 0);
    chk("st_mem_addr", {22'd0, bus.mem_addr}, 4);
    step(); bus.l_req = 0; settle();
    chk("st_l_rvalid", {31'd0, bus.l_rvalid}, 1);
    chk("st_l_rdata", bus.l_rdata, 32'hA000_0004);
    chk("st_f_rvalid", {31'd0, bus.f_rvalid}, 0);
    chk("st_f_resume", {31'd0, bus.f_gnt}, 1);
    // locked burst write of 0xDEADBEEF to 0x0C with fetch pending
    step(); bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'hC; bus.l_wdata = 32'hDEAD_BEEF; bus.l_lock = 1; settle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lk_wait%0d", k), {31'd0, bus.f_gnt}, 1);
      step();
    end
    chk("lk_b1_gnt", {31'd0, bus.l_gnt}, 1);
    chk("lk_b1_we", {31'd0, bus.mem_we}, 1);
    chk("lk_b1_addr", {22'd0, bus.mem_addr}, 3);
    chk("lk_b1_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("lk_b1_locked", {31'd0, bus.locked}, 0);
    for (int k = 2; k <= 3; k++) begin
      step();
      chk($sformatf("lk_b%0d_gnt", k), {31'd0, bus.l_gnt}, 1);
      chk($sformatf("lk_b%0d_we", k), {31'd0, bus.mem_we}, 1);
      chk($sformatf("lk_b%0d_locked", k), {31'd0, bus.locked}, 1);
      chk($sformatf("lk_b%0d_fgnt", k), {31'd0, bus.f_gnt}, 0);
      chk($sformatf("lk_b%0d_ack", k), {31'd0, bus.l_rvalid}, 1);
      chk($sformatf("lk_b%0d_ackdata", k), bus.l_rdata, 0);
      chk($sformatf("lk_b%0d_ackerr", k), {31'd0, bus.l_err}, 0);
    end
    step(); bus.l_req = 0; bus.l_lock = 0; settle();
    chk("lk_drop_fgnt", {31'd0, bus.f_gnt}, 0);
    chk("lk_drop_locked", {31'd0, bus.locked}, 1);
    step(); bus.f_pc = 32'hC; settle();
    chk("lk_after_fgnt", {31'd0, bus.f_gnt}, 1);
    chk("lk_after_locked", {31'd0, bus.locked}, 0);
    step(); bus.f_req = 0; settle();
    chk("lk_readback", bus.f_rdata, 32'hDEAD_BEEF);
    // misaligned fetch
    step(); bus.f_req = 1; bus.f_pc = 32'h6; settle();
    chk("mis_gnt", {31'd0, bus.f_gnt}, 1);
    chk("mis_mem_en", {31'd0, bus.mem_en}, 0);
    step(); bus.f_req = 0; settle();
    chk("mis_rvalid", {31'd0, bus.f_rvalid}, 1);
    chk("mis_err", {31'd0, bus.f_err}, 1);
    chk("mis_rdata", bus.f_rdata, 0);
    // pipelined fetch then aliased loader read
    step(); bus.f_req = 1; bus.f_pc = 32'h4; settle();
    chk("pp_f_gnt", {31'd0, bus.f_gnt}, 1);
    step(); bus.f_req = 0; bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h8000_0014; settle();
    chk("pp_l_gnt", {31'd0, bus.l_gnt}, 1);
    chk("pp_l_addr", {22'd0, bus.mem_addr}, 5);
    chk("pp_f_rvalid", {31'd0, bus.f_rvalid}, 1);
    chk("pp_f_rdata", bus.f_rdata, 32'hA000_0001);
    chk("pp_l_rvalid0", {31'd0, bus.l_rvalid}, 0);
    step(); bus.l_req = 0; settle();
    chk("pp_l_rvalid", {31'd0, bus.l_rvalid}, 1);
    chk("pp_l_rdata", bus.l_rdata, 32'hA000_0005);
    chk("pp_f_rvalid1", {31'd0, bus.f_rvalid}, 0);
    chk("pp_f_rdata1", bus.f_rdata, 0);
    // reset right after a locked grant drops the response
    step(); bus.l_req = 1; bus.l_lock = 1; settle();
    chk("rr_gnt", {31'd0, bus.l_gnt}, 1);
    step();
    chk("rr_locked", {31'd0, bus.locked}, 1);
    #3 reset = 1'b0; settle();
    chk("rr_l_gnt0", {31'd0, bus.l_gnt}, 0);
    chk("rr_mem_en0", {31'd0, bus.mem_en}, 0);
    chk("rr_locked0", {31'd0, bus.locked}, 0);
    step(); bus.l_req = 0; bus.l_lock = 0; settle();
    chk("rr_l_rvalid", {31'd0, bus.l_rvalid}, 0);
    chk("rr_f_rvalid", {31'd0, bus.f_rvalid}, 0);
    reset = 1'b1;
    step();
    chk("rr_rel_locked", {31'd0, bus.locked}, 0);
    chk("rr_rel_l_rvalid", {31'd0, bus.l_rvalid}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
